// File: rtl/stump_alu_pkg.sv
// Shared encodings for the sequential Stump ALU: function codes, shift types,
// flag bit positions and FSM states.
package stump_alu_pkg;

    localparam int unsigned FUNC_W = 3;
    localparam int unsigned SHT_W  = 2;
    localparam int unsigned FLAG_W = 4;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_C = 0;

    typedef enum logic [FUNC_W-1:0] {
        FN_ADD  = 3'b000,
        FN_ADC  = 3'b001,
        FN_SUB  = 3'b010,
        FN_SBC  = 3'b011,
        FN_AND  = 3'b100,
        FN_OR   = 3'b101,
        FN_XOR  = 3'b110,
        FN_MOVB = 3'b111
    } func_e;

    typedef enum logic [SHT_W-1:0] {
        SH_NONE = 2'b00,
        SH_ASR  = 2'b01,
        SH_ROR  = 2'b10,
        SH_RRC  = 2'b11
    } shift_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/stump_alu_seq_if.sv
// Operation/result handshake bundle between the register-read stage, the ALU
// and write-back.
interface stump_alu_seq_if
    import stump_alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned SHAMT_W = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [FUNC_W-1:0]  func;
    logic [SHT_W-1:0]   shift_type;
    logic [SHAMT_W-1:0] shamt;
    logic               set_flags;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   result;
    logic [FLAG_W-1:0]  flags_out;
    logic               busy;

    modport master (
        output in_valid, op_a, op_b, func, shift_type, shamt, set_flags, out_ready,
        input  in_ready, out_valid, result, flags_out, busy
    );

    modport slave (
        input  in_valid, op_a, op_b, func, shift_type, shamt, set_flags, out_ready,
        output in_ready, out_valid, result, flags_out, busy
    );
endinterface

// File: rtl/stump_alu_seq_core.sv
// Combinational Stump ALU function block: arithmetic at WIDTH+1 bits, logic
// ops take their carry from the shifter (or the carry snapshot when unshifted).
module stump_alu_core
    import stump_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0]  a_i,
    input  logic [WIDTH-1:0]  b_i,
    input  func_e             func_i,
    input  logic              carry_i,
    input  logic              shift_carry_i,
    input  logic              shifted_i,
    output logic [WIDTH-1:0]  result_o,
    output logic [FLAG_W-1:0] nzvc_o
);

    logic             arith;
    logic             cin;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;

    always_comb begin
        arith = ~func_i[2];
        b_eff = func_i[1] ? ~b_i : b_i;
        // Odd codes chain the carry in; SUB forces the +1 of two's complement
        cin   = func_i[0] ? carry_i : func_i[1];
        sum   = {1'b0, a_i} + {1'b0, b_eff} + (WIDTH+1)'(cin);

        case (func_i)
            FN_AND:  result_o = a_i & b_i;
            FN_OR:   result_o = a_i | b_i;
            FN_XOR:  result_o = a_i ^ b_i;
            FN_MOVB: result_o = b_i;
            default: result_o = sum[WIDTH-1:0];
        endcase

        nzvc_o         = '0;
        nzvc_o[FLAG_N] = result_o[WIDTH-1];
        nzvc_o[FLAG_Z] = (result_o == '0);
        nzvc_o[FLAG_V] = arith & (a_i[WIDTH-1] == b_eff[WIDTH-1])
                               & (sum[WIDTH-1] != a_i[WIDTH-1]);
        nzvc_o[FLAG_C] = arith ? sum[WIDTH] : (shifted_i ? shift_carry_i : carry_i);
    end

endmodule

// File: rtl/stump_alu_seq.sv
// Sequential Stump ALU: valid/ready operation intake, bit-serial shift of
// operand A, registered result and an internal NZVC flag register.
module stump_alu_seq
    import stump_alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned SHAMT_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    stump_alu_seq_if.slave  bus
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
    func_e              func_q, func_d;
    shift_e             sht_q, sht_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               sf_q, sf_d, csnap_q, csnap_d, lc_q, lc_d;
    logic [FLAG_W-1:0]  flags_q, flags_d;

    logic               in_ready_c, accept, need_shift, in_shift, load, finish, commit_sf;
    logic [WIDTH-1:0]   step_a, core_a, core_b, core_result;
    logic               step_out;
    func_e              core_func;
    logic               core_carry;
    logic [FLAG_W-1:0]  core_nzvc;

    assign in_shift   = (state_q == ST_SHIFT);
    assign in_ready_c = (state_q == ST_IDLE) | ((state_q == ST_DONE) & bus.out_ready);
    assign accept     = bus.in_valid & in_ready_c;
    assign need_shift = (shift_e'(bus.shift_type) != SH_NONE) && (bus.shamt != '0);

    // One shift step of the held operand; the bit leaving A[0] is the shift carry
    always_comb begin
        step_out = a_q[0];
        case (sht_q)
            SH_ASR:  step_a = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
            SH_ROR:  step_a = {a_q[0],       a_q[WIDTH-1:1]};
            SH_RRC:  step_a = {lc_q,         a_q[WIDTH-1:1]};
            default: step_a = a_q;
        endcase
    end

    // Unshifted ops compute straight from the bus on the accept edge
    assign core_a     = in_shift ? step_a  : bus.op_a;
    assign core_b     = in_shift ? b_q     : bus.op_b;
    assign core_func  = in_shift ? func_q  : func_e'(bus.func);
    assign core_carry = in_shift ? csnap_q : flags_q[FLAG_C];
    assign commit_sf  = in_shift ? sf_q    : bus.set_flags;

    stump_alu_core #(.WIDTH(WIDTH)) u_core (
        .a_i           (core_a),
        .b_i           (core_b),
        .func_i        (core_func),
        .carry_i       (core_carry),
        .shift_carry_i (step_out),
        .shifted_i     (in_shift),
        .result_o      (core_result),
        .nzvc_o        (core_nzvc)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        func_d   = func_q;
        sht_d    = sht_q;
        cnt_d    = cnt_q;
        sf_d     = sf_q;
        csnap_d  = csnap_q;
        lc_d     = lc_q;
        result_d = result_q;
        flags_d  = flags_q;
        load     = 1'b0;
        finish   = 1'b0;

        case (state_q)
            ST_IDLE: load = accept;
            ST_SHIFT: begin
                a_d   = step_a;
                lc_d  = step_out;
                cnt_d = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    finish  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                load = accept;
                if (!accept && bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            a_d     = bus.op_a;
            b_d     = bus.op_b;
            func_d  = func_e'(bus.func);
            sht_d   = shift_e'(bus.shift_type);
            cnt_d   = bus.shamt;
            sf_d    = bus.set_flags;
            csnap_d = flags_q[FLAG_C];
            lc_d    = flags_q[FLAG_C];
            if (need_shift) begin
                state_d = ST_SHIFT;
            end else begin
                finish  = 1'b1;
                state_d = ST_DONE;
            end
        end

        if (finish) begin
            result_d = core_result;
            if (commit_sf) flags_d = core_nzvc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            func_q   <= FN_ADD;
            sht_q    <= SH_NONE;
            cnt_q    <= '0;
            sf_q     <= 1'b0;
            csnap_q  <= 1'b0;
            lc_q     <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            func_q   <= func_d;
            sht_q    <= sht_d;
            cnt_q    <= cnt_d;
            sf_q     <= sf_d;
            csnap_q  <= csnap_d;
            lc_q     <= lc_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.result    = result_q;
    assign bus.flags_out = flags_q;
    assign bus.busy      = in_shift;

endmodule

// File: tb/tb_stump_alu_seq.sv
// Directed bench for stump_alu_seq: expected results are queued at each accept
// and popped when out_valid appears.
module tb_stump_alu_seq;
    import stump_alu_pkg::*;

    localparam int unsigned W  = 16;
    localparam int unsigned SW = 4;

    logic clk;
    logic rst_n;

    stump_alu_seq_if #(.WIDTH(W), .SHAMT_W(SW)) bif ();

    stump_alu_seq #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    typedef struct packed {
        logic [W-1:0]      res;
        logic [FLAG_W-1:0] fl;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present an op at a falling edge and hold it until accepted; expectation queued at the accept edge
    task automatic offer(input func_e f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input shift_e st, input logic [SW-1:0] sh, input logic sf,
                         input logic hold, input logic [W-1:0] er, input logic [FLAG_W-1:0] ef);
        int w;
        w = 0;
        bif.func       = f;
        bif.op_a       = a;
        bif.op_b       = b;
        bif.shift_type = st;
        bif.shamt      = sh;
        bif.set_flags  = sf;
        bif.in_valid   = 1'b1;
        #1;
        while (!bif.in_ready && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!bif.in_ready) begin
            n_tests++;
            n_fail++;
            $error("FAIL offer_timeout: observed in_ready 0 expected 1");
        end
        @(posedge clk);
        exp_q.push_back('{res: er, fl: ef});
        #1;
        if (!hold) bif.in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid, checking latency, SHIFT-cycle count, result and flags
    task automatic wait_out(input string tag, input int exp_lat, input int exp_busy);
        int   cyc;
        int   bcyc;
        exp_t e;
        cyc  = 0;
        bcyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (bif.busy) bcyc++;
        end while (!bif.out_valid && cyc < 40);
        check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_busy"}, 32'(bcyc), 32'(exp_busy));
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s_sb: observed empty scoreboard expected one entry", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_res"}, 32'(bif.result), 32'(e.res));
            check({tag, "_flags"}, 32'(bif.flags_out), 32'(e.fl));
        end
    endtask

    initial begin
        int ov_cnt;
        exp_t dropped;

        rst_n          = 1'b0;
        bif.in_valid   = 1'b0;
        bif.op_a       = '0;
        bif.op_b       = '0;
        bif.func       = '0;
        bif.shift_type = '0;
        bif.shamt      = '0;
        bif.set_flags  = 1'b0;
        bif.out_ready  = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(bif.out_valid), 32'(0));
        check("rst_result",    32'(bif.result),    32'(0));
        check("rst_flags",     32'(bif.flags_out), 32'(0));
        check("rst_in_ready",  32'(bif.in_ready),  32'(1));
        check("rst_busy",      32'(bif.busy),      32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Signed overflow into the sign bit
        offer(FN_ADD, 16'h7FFF, 16'h0001, SH_NONE, 4'd0, 1'b1, 1'b0, 16'h8000, 4'b1010);
        wait_out("add_ovf", 1, 0);

        // Equal operands subtract to zero with no borrow
        offer(FN_SUB, 16'h0005, 16'h0005, SH_NONE, 4'd0, 1'b1, 1'b0, 16'h0000, 4'b0101);
        wait_out("sub_zero", 1, 0);

        // Carry-out then back-to-back ADC consuming it
        offer(FN_ADD, 16'hFFFF, 16'h0001, SH_NONE, 4'd0, 1'b1, 1'b1, 16'h0000, 4'b0101);
        wait_out("add_wrap", 1, 0);
        offer(FN_ADC, 16'h0001, 16'h0001, SH_NONE, 4'd0, 1'b1, 1'b0, 16'h0003, 4'b0000);
        wait_out("adc_b2b", 1, 0);

        // ASR by 3; logic C comes from the last bit shifted out
        offer(FN_AND, 16'h8014, 16'hFFFF, SH_ASR, 4'd3, 1'b1, 1'b0, 16'hF002, 4'b1001);
        wait_out("and_asr", 4, 3);

        // ROR by 4 with a wrapped bit, then hold the result under backpressure
        offer(FN_XOR, 16'h00F8, 16'h0FF0, SH_ROR, 4'd4, 1'b1, 1'b0, 16'h8FFF, 4'b1001);
        bif.out_ready = 1'b0;
        wait_out("xor_ror", 5, 4);
        bif.func       = FN_SBC;
        bif.op_a       = 16'h0010;
        bif.op_b       = 16'h0001;
        bif.shift_type = SH_NONE;
        bif.shamt      = 4'd0;
        bif.set_flags  = 1'b1;
        bif.in_valid   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(bif.out_valid), 32'(1));
            check("bp_result",    32'(bif.result),    32'(16'h8FFF));
            check("bp_flags",     32'(bif.flags_out), 32'(4'b1001));
            check("bp_in_ready",  32'(bif.in_ready),  32'(0));
        end
        bif.out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(bif.in_ready), 32'(1));
        @(posedge clk);
        exp_q.push_back('{res: 16'h000F, fl: 4'b0001});
        #1;
        bif.in_valid = 1'b0;
        wait_out("sbc_release", 1, 0);

        // RRC seeded from C=1, flags left untouched
        offer(FN_ADD, 16'h0002, 16'h0000, SH_RRC, 4'd2, 1'b0, 1'b0, 16'h4000, 4'b0001);
        wait_out("rrc_noflags", 3, 2);

        // Reset mid-shift discards the op and clears flags
        offer(FN_ADD, 16'h0001, 16'h0000, SH_RRC, 4'd8, 1'b1, 1'b0, 16'h0000, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        check("mid_shift_busy", 32'(bif.busy), 32'(1));
        rst_n = 1'b0;
        #1;
        check("rstmid_out_valid", 32'(bif.out_valid), 32'(0));
        check("rstmid_flags",     32'(bif.flags_out), 32'(0));
        check("rstmid_in_ready",  32'(bif.in_ready),  32'(1));
        check("rstmid_busy",      32'(bif.busy),      32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        dropped = exp_q.pop_back();
        ov_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bif.out_valid) ov_cnt++;
        end
        check("no_stale_result", 32'(ov_cnt), 32'(0));
        check("post_rst_flags",  32'(bif.flags_out), 32'(0));
        check("post_rst_ready",  32'(bif.in_ready),  32'(1));

        // shift_type none with nonzero shamt computes without shifting
        offer(FN_MOVB, 16'h1234, 16'h0000, SH_NONE, 4'd5, 1'b1, 1'b0, 16'h0000, 4'b0100);
        wait_out("movb_noshift", 1, 0);

        @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
